// File: rtl/glyph_rain_pkg.sv
// glyph_rain_pkg: shared mode/level encodings, LFSR constants, column-state type and the trail level rule
package glyph_rain_pkg;
  localparam logic [1:0] MODE_RAIN   = 2'd0;
  localparam logic [1:0] MODE_FREEZE = 2'd1;
  localparam logic [1:0] MODE_STATIC = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;
  localparam logic [1:0] LVL_DARK = 2'd0;
  localparam logic [1:0] LVL_TAIL = 2'd1;
  localparam logic [1:0] LVL_BODY = 2'd2;
  localparam logic [1:0] LVL_HEAD = 2'd3;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  typedef struct packed {
    logic [6:0] head;
    logic [1:0] speed;
    logic [1:0] tick;
    logic [3:0] trail;
    logic       active;
  } col_t;
  function automatic logic [1:0] rain_level(col_t e, logic [6:0] row);
    logic signed [7:0] d;
    d = $signed({1'b0, e.head}) - $signed({1'b0, row});
    return (!e.active || d[7] || d > $signed({4'b0, e.trail})) ? LVL_DARK :
           (d == 8'sd0) ? LVL_HEAD :
           (d <= $signed({5'b0, e.trail[3:1]})) ? LVL_BODY : LVL_TAIL;
  endfunction
endpackage

// File: rtl/glyph_rain_lfsr.sv
// glyph_rain_lfsr: 16-bit Galois LFSR with step enable (clk, reset, step in; state out)
module glyph_rain_lfsr
  import glyph_rain_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] state
);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SEED;
    else if (step) state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/glyph_rain_engine.sv
// glyph_rain_engine: column rain state, vblank update FSM and 2-stage pixel pipeline (in: clk, reset, hpos, vpos, display_on, frame_start, mode; out: glyph_index, g_x, g_y, level, pix_valid, busy, overrun)
module glyph_rain_engine
  import glyph_rain_pkg::*;
#(
  parameter int          H_BITS    = 11,
  parameter int          V_BITS    = 10,
  parameter int          COLS      = 80,
  parameter int          ROWS      = 40,
  parameter int          CELL_H    = 12,
  parameter int          GLYPHS    = 51,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [H_BITS-1:0] hpos,
  input  logic [V_BITS-1:0] vpos,
  input  logic              display_on,
  input  logic              frame_start,
  input  logic [1:0]        mode,
  output logic [5:0]        glyph_index,
  output logic [2:0]        g_x,
  output logic [3:0]        g_y,
  output logic [1:0]        level,
  output logic              pix_valid,
  output logic              busy,
  output logic              overrun
);
  localparam int CW = H_BITS - 3;
  localparam int RW = $clog2(ROWS);
  localparam int IW = $clog2(COLS + 1);
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_UPDATE = 1'b1;
  col_t            cols [COLS];
  logic            state;
  logic [IW-1:0]   idx;
  logic [7:0]      frame;
  logic [15:0]     lfsr;
  col_t            cur, nxt;
  logic            respawn, adv;
  logic [V_BITS-1:0] prev_vpos;
  logic [RW-1:0]   row_q, row_n;
  logic [3:0]      gy_q, gy_n;
  logic            line, wrap;
  logic [CW-1:0]   s1_col;
  logic [RW-1:0]   s1_row;
  logic [2:0]      s1_gx;
  logic [3:0]      s1_gy;
  logic            s1_pv;
  logic [1:0]      s1_mode;
  col_t            s1_ent;
  logic [1:0]      lvl;
  logic [8:0]      base, g;
  logic            unused;
  assign unused = ^{frame[7:6], frame[1:0], lfsr[15:11]};
  assign busy = state == ST_UPDATE;
  glyph_rain_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (busy),
    .state (lfsr)
  );
  always_comb begin
    cur = cols[idx];
    adv = cur.tick == cur.speed;
    respawn = (8'(cur.head) + 8'd1 > 8'(ROWS) + 8'(cur.trail)) || (!cur.active && lfsr[3:0] == 4'd0);
    nxt = cur;
    nxt.tick = adv ? 2'd0 : cur.tick + 2'd1;
    nxt.head = adv ? cur.head + 7'd1 : cur.head;
    if (respawn) begin
      nxt.head   = '0;
      nxt.speed  = lfsr[5:4];
      nxt.tick   = '0;
      nxt.trail  = lfsr[9:6] | 4'd3;
      nxt.active = lfsr[10];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      frame   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < COLS; i++) cols[i] <= '0;
    end else if (state == ST_UPDATE) begin
      cols[idx] <= nxt;
      idx       <= idx + 1'b1;
      state     <= (idx == IW'(COLS - 1)) ? ST_IDLE : ST_UPDATE;
      overrun   <= overrun | frame_start;
    end else if (frame_start && mode == MODE_RAIN) begin
      state <= ST_UPDATE;
      idx   <= '0;
      frame <= frame + 8'd1;
    end
  // row/g_y follow line changes incrementally so no divide by CELL_H is needed
  assign line  = vpos != prev_vpos;
  assign wrap  = gy_q == 4'(CELL_H - 1);
  assign gy_n  = (vpos == '0) ? '0 : !line ? gy_q : wrap ? '0 : gy_q + 4'd1;
  assign row_n = (vpos == '0) ? '0 : (line && wrap && row_q != RW'(ROWS - 1)) ? row_q + 1'b1 : row_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev_vpos <= '0;
      row_q     <= '0;
      gy_q      <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      s1_pv     <= 1'b0;
      s1_mode   <= '0;
      s1_ent    <= '0;
    end else begin
      prev_vpos <= vpos;
      row_q     <= row_n;
      gy_q      <= gy_n;
      s1_col    <= hpos[H_BITS-1:3];
      s1_row    <= row_n;
      s1_gx     <= hpos[2:0];
      s1_gy     <= gy_n;
      s1_pv     <= display_on;
      s1_mode   <= mode;
      s1_ent    <= (hpos[H_BITS-1:3] < CW'(COLS)) ? cols[hpos[H_BITS-1:3]] : '0;
    end
  always_comb begin
    lvl = (!s1_pv || s1_col >= CW'(COLS) || s1_mode == MODE_OFF) ? LVL_DARK :
          (s1_mode == MODE_STATIC) ? LVL_BODY : rain_level(s1_ent, 7'(s1_row));
    base = 9'(s1_col) * 9'd3 + 9'(s1_row) * 9'd5 + ((lvl == LVL_HEAD) ? 9'(frame[5:2]) : 9'd0);
    g = base;
    for (int i = 0; i < 511 / GLYPHS + 1; i++) g = (g >= 9'(GLYPHS)) ? g - 9'(GLYPHS) : g;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      glyph_index <= '0;
      g_x         <= '0;
      g_y         <= '0;
      level       <= '0;
      pix_valid   <= 1'b0;
    end else begin
      glyph_index <= g[5:0];
      g_x         <= s1_gx;
      g_y         <= s1_gy;
      level       <= lvl;
      pix_valid   <= s1_pv;
    end
endmodule

// File: tb/tb_glyph_rain_engine.sv
// tb_glyph_rain_engine: directed bench with column-state model and pixel scoreboard for glyph_rain_engine
module tb_glyph_rain_engine;
  localparam int COLS = 80, ROWS = 40, CELL_H = 12, GLYPHS = 51;
  typedef struct {
    int          due;
    logic [15:0] v;
    int          h;
    int          vv;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic        display_on, frame_start;
  logic [1:0]  mode;
  logic [5:0]  glyph_index;
  logic [2:0]  g_x;
  logic [3:0]  g_y;
  logic [1:0]  level;
  logic        pix_valid, busy, overrun;
  int checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t ce;
  logic [6:0]  m_head  [COLS];
  logic [1:0]  m_speed [COLS];
  logic [1:0]  m_tick  [COLS];
  logic [3:0]  m_trail [COLS];
  logic        m_act   [COLS];
  logic [15:0] m_lfsr;
  logic [7:0]  m_frame;
  glyph_rain_engine dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .frame_start (frame_start),
    .mode        (mode),
    .glyph_index (glyph_index),
    .g_x         (g_x),
    .g_y         (g_y),
    .level       (level),
    .pix_valid   (pix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ce = sb.pop_front();
      checks++;
      assert (ce.due == cyc && {pix_valid, level, glyph_index, g_x, g_y} === ce.v) else begin
        errors++;
        $error("FAIL pix h=%0d v=%0d: got pv=%0b lvl=%0d gi=%0d gx=%0d gy=%0d, expected pv=%0b lvl=%0d gi=%0d gx=%0d gy=%0d (due %0d, now %0d)",
               ce.h, ce.vv, pix_valid, level, glyph_index, g_x, g_y,
               ce.v[15], ce.v[14:13], ce.v[12:7], ce.v[6:4], ce.v[3:0], ce.due, cyc);
      end
    end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < COLS; c++) begin
      m_head[c] = 0; m_speed[c] = 0; m_tick[c] = 0; m_trail[c] = 0; m_act[c] = 0;
    end
    m_lfsr = 16'hACE1;
    m_frame = 0;
  endtask
  task automatic model_sweep();
    m_frame++;
    for (int c = 0; c < COLS; c++) begin
      if (int'(m_head[c]) + 1 > ROWS + int'(m_trail[c]) || (!m_act[c] && m_lfsr[3:0] == 4'd0)) begin
        m_head[c] = 0; m_speed[c] = m_lfsr[5:4]; m_tick[c] = 0;
        m_trail[c] = m_lfsr[9:6] | 4'd3; m_act[c] = m_lfsr[10];
      end else if (m_tick[c] == m_speed[c]) begin
        m_tick[c] = 0; m_head[c] = m_head[c] + 7'd1;
      end else m_tick[c] = m_tick[c] + 2'd1;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  endtask
  function automatic logic [1:0] exp_level(int c, int r, logic [1:0] md, logic dv);
    int d;
    if (!dv || c >= COLS || md == 2'd3) return 2'd0;
    if (md == 2'd2) return 2'd2;
    if (!m_act[c]) return 2'd0;
    d = int'(m_head[c]) - r;
    if (d < 0 || d > int'(m_trail[c])) return 2'd0;
    if (d == 0) return 2'd3;
    if (d <= int'(m_trail[c]) / 2) return 2'd2;
    return 2'd1;
  endfunction
  task automatic pix(int h, int v, logic dv);
    int c, r;
    logic [1:0] l;
    logic [5:0] gi;
    c = h / 8;
    r = v / CELL_H;
    if (r > ROWS - 1) r = ROWS - 1;
    @(posedge clk); #1;
    hpos = 11'(h); vpos = 10'(v); display_on = dv;
    l = exp_level(c, r, mode, dv);
    gi = 6'((c * 3 + r * 5 + (l == 2'd3 ? int'(m_frame[5:2]) : 0)) % GLYPHS);
    sb.push_back('{due: cyc + 2, v: {dv, l, gi, 3'(h % 8), 4'(v % CELL_H)}, h: h, vv: v});
  endtask
  task automatic sweep(logic [1:0] md, int step, string tag);
    mode = md;
    for (int v = 0; v < 480; v++) begin
      for (int c = 0; c < 82; c += step) pix(c * 8 + (c + v) % 8, v, ((v + c) % 17) != 0);
      if (step > 1) pix(79 * 8 + v % 8, v, 1'b1);
    end
    @(posedge clk); #1;
    hpos = 0; vpos = 0; display_on = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask
  task automatic pulse_fs();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask
  task automatic run_frame(string tag);
    int n = 0;
    pulse_fs();
    while (busy && n < 200) begin n++; @(posedge clk); #1; end
    chk(tag, n, 80);
    model_sweep();
    repeat (3) @(posedge clk);
  endtask
  initial begin
    int n;
    reset = 1; hpos = 0; vpos = 0; display_on = 0; frame_start = 0; mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_outs", {pix_valid, level, glyph_index, g_x, g_y}, 0);
    reset = 0;
    pulse_fs();
    chk("busy_rise", busy, 1);
    repeat (20) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    @(posedge clk); #1;
    chk("midrst_outs", {pix_valid, level, glyph_index, g_x, g_y}, 0);
    reset = 0;
    model_reset();
    run_frame("busy_len_first");
    chk("overrun_clear", overrun, 0);
    pulse_fs();
    n = 0;
    while (busy && n < 200) begin
      n++;
      frame_start = (n == 10);
      @(posedge clk); #1;
    end
    frame_start = 0;
    chk("busy_len_overlap", n, 80);
    chk("overrun_set", overrun, 1);
    model_sweep();
    repeat (3) @(posedge clk);
    for (int f = 0; f < 15; f++) run_frame("busy_len");
    mode = 2'd1;
    for (int f = 0; f < 5; f++) begin
      pulse_fs();
      chk("freeze_idle", busy, 0);
    end
    mode = 2'd3;
    pulse_fs();
    chk("off_idle", busy, 0);
    sweep(2'd0, 1, "sb_drain_rain");
    sweep(2'd2, 9, "sb_drain_static");
    sweep(2'd3, 9, "sb_drain_off");
    chk("overrun_sticky", overrun, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
